// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size and direction
// encodings as produced by the decoder, and the sequencing FSM state type.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   size, sign, addr_lo  - access size, load sign-extension, byte offset
//   wdata                - store data from rs2
//   bus_rdata            - word read from the bus
//   be                   - byte enables for the access
//   wdata_rep            - store data replicated across all lanes
//   rdata_ext            - load data shifted down and sign/zero extended
//   misalign             - access cannot be issued (unaligned or illegal size)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = shifted;
    misalign  = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign & shifted[15]}}, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      SZ_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        misalign  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one req/ack transaction on a word-addressed data bus
// per memory instruction and stalls the pipeline while it is outstanding.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   req_valid, mem_rw, mem_size,
//   mem_sign, addr, wdata            - memory request from decode/ALU
//   stall, done, misalign, rdata     - pipeline handshake and load result
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata                - data bus request (held until ack)
//   bus_ack, bus_rdata               - data bus response
//
// state   | meaning
// IDLE    | waiting for a memory instruction; launch on req_valid
// BUS     | bus_req asserted, waiting for bus_ack
// DONE    | retire pulse (done, plus misalign if rejected)
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t state, state_nxt;

  logic       lat_rw;
  logic [1:0] lat_size;
  logic       lat_sign;
  logic [1:0] lat_addr_lo;
  logic       fault_q;

  logic       launch;
  logic [1:0] al_size;
  logic       al_sign;
  logic [1:0] al_addr_lo;
  logic [3:0] al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic       al_mis;

  assign launch = (state == ST_IDLE) && req_valid;

  // In IDLE the aligner evaluates the incoming request (lanes, fault check);
  // afterwards it evaluates the latched request so load extraction lines up
  // with bus_rdata at ack time.
  assign al_size    = (state == ST_IDLE) ? mem_size  : lat_size;
  assign al_sign    = (state == ST_IDLE) ? mem_sign  : lat_sign;
  assign al_addr_lo = (state == ST_IDLE) ? addr[1:0] : lat_addr_lo;

  lsu_align u_align (
    .size      (al_size),
    .sign      (al_sign),
    .addr_lo   (al_addr_lo),
    .wdata     (wdata),
    .bus_rdata (bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = al_mis ? ST_DONE : ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rw      <= LOAD;
      lat_size    <= SZ_B;
      lat_sign    <= 1'b0;
      lat_addr_lo <= 2'b00;
      fault_q     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'b0000;
      bus_wdata   <= 32'h0;
    end else if (launch) begin
      lat_rw      <= mem_rw;
      lat_size    <= mem_size;
      lat_sign    <= mem_sign;
      lat_addr_lo <= addr[1:0];
      fault_q     <= al_mis;
      bus_we      <= mem_rw;
      bus_addr    <= {addr[ADDR_W-1:2], 2'b00};
      bus_be      <= al_be;
      bus_wdata   <= al_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0;
    end else if ((state == ST_BUS) && bus_ack && (lat_rw == LOAD)) begin
      rdata <= al_rdata;
    end
  end

  // Decoded straight from the state flop so an async reset drops bus_req
  // in the same cycle.
  assign bus_req  = (state == ST_BUS);
  assign done     = (state == ST_DONE);
  assign misalign = (state == ST_DONE) && fault_q;
  assign stall    = launch || (state == ST_BUS);

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        misalign;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  int          obs_stall;
  int          obs_done_cyc;
  logic        obs_mis;
  logic        obs_req;
  logic [31:0] obs_rdata;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_we;
  logic        obs_fin;

  lsu #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .mem_rw    (mem_rw),
    .mem_size  (mem_size),
    .mem_sign  (mem_sign),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .misalign  (misalign),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One memory instruction; dly = extra BUS wait cycles before ack.
  task automatic run_op(input logic rw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
    int bus_cyc;
    obs_stall    = 0;
    obs_done_cyc = 0;
    obs_mis      = 1'b0;
    obs_req      = 1'b0;
    obs_fin      = 1'b0;
    obs_addr     = 32'h0;
    obs_be       = 4'h0;
    obs_wdata    = 32'h0;
    obs_we       = 1'b0;
    bus_cyc      = 0;
    @(negedge clk);
    req_valid = 1'b1;
    mem_rw    = rw;
    mem_size  = sz;
    mem_sign  = sg;
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    for (int cyc = 1; cyc <= 20 && !obs_fin; cyc++) begin
      #1;
      if (stall) obs_stall++;
      if (bus_req) begin
        bus_cyc++;
        obs_req = 1'b1;
        if (bus_cyc == 1) begin
          obs_addr  = bus_addr;
          obs_be    = bus_be;
          obs_wdata = bus_wdata;
          obs_we    = bus_we;
        end
      end
      if (done) begin
        obs_done_cyc = cyc;
        obs_mis      = misalign;
        obs_rdata    = rdata;
        obs_fin      = 1'b1;
        req_valid    = 1'b0;
      end
      bus_ack   = bus_req && (bus_cyc == dly + 1);
      bus_rdata = bus_ack ? rd : 32'h0;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    req_valid = 1'b0;
    chk("op_finished", {31'h0, obs_fin}, 32'h1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_rw    = 1'b0;
    mem_size  = 2'b00;
    mem_sign  = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;

    #22;
    chk("rst_bus_req",   {31'h0, bus_req},  32'h0);
    chk("rst_bus_we",    {31'h0, bus_we},   32'h0);
    chk("rst_done",      {31'h0, done},     32'h0);
    chk("rst_misalign",  {31'h0, misalign}, 32'h0);
    chk("rst_stall",     {31'h0, stall},    32'h0);
    chk("rst_bus_addr",  bus_addr,          32'h0);
    chk("rst_bus_be",    {28'h0, bus_be},   32'h0);
    chk("rst_bus_wdata", bus_wdata,         32'h0);
    chk("rst_rdata",     rdata,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW, ack on 2nd BUS cycle
    run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    chk("sw_addr",  obs_addr,                32'h100);
    chk("sw_be",    {28'h0, obs_be},         32'hF);
    chk("sw_wdata", obs_wdata,               32'hDEADBEEF);
    chk("sw_we",    {31'h0, obs_we},         32'h1);
    chk("sw_stall", obs_stall,               32'd3);
    chk("sw_done",  obs_done_cyc,            32'd4);
    chk("sw_mis",   {31'h0, obs_mis},        32'h0);

    // LB / LBU at byte 3
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0);
    chk("lb_rdata", obs_rdata,               32'hFFFFFF80);
    chk("lb_be",    {28'h0, obs_be},         32'h8);
    chk("lb_we",    {31'h0, obs_we},         32'h0);
    chk("lb_stall", obs_stall,               32'd2);
    chk("lb_done",  obs_done_cyc,            32'd3);
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0);
    chk("lbu_rdata", obs_rdata,              32'h00000080);

    // LH / LHU at upper half
    run_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80010000, 0);
    chk("lh_rdata", obs_rdata,               32'hFFFF8001);
    chk("lh_be",    {28'h0, obs_be},         32'hC);
    chk("lh_addr",  obs_addr,                32'h100);
    run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80010000, 2);
    chk("lhu_rdata", obs_rdata,              32'h00008001);
    chk("lhu_stall", obs_stall,              32'd4);

    // SB at byte 1; rdata untouched by stores
    run_op(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AB, 32'h0, 0);
    chk("sb_addr",  obs_addr,                32'h200);
    chk("sb_be",    {28'h0, obs_be},         32'h2);
    chk("sb_wdata", obs_wdata,               32'hABABABAB);
    chk("sb_rdata", obs_rdata,               32'h00008001);

    // Misaligned LW
    run_op(1'b0, 2'b10, 1'b1, 32'h102, 32'h0, 32'h0, 0);
    chk("mis_flag",  {31'h0, obs_mis},       32'h1);
    chk("mis_done",  obs_done_cyc,           32'd2);
    chk("mis_stall", obs_stall,              32'd1);
    chk("mis_req",   {31'h0, obs_req},       32'h0);
    chk("mis_rdata", obs_rdata,              32'h00008001);

    // Illegal size
    run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    chk("ill_flag",  {31'h0, obs_mis},       32'h1);
    chk("ill_req",   {31'h0, obs_req},       32'h0);

    // Reset while in BUS
    @(negedge clk);
    req_valid = 1'b1;
    mem_rw    = 1'b0;
    mem_size  = 2'b10;
    mem_sign  = 1'b0;
    addr      = 32'h300;
    bus_ack   = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_bus_req", {31'h0, bus_req},     32'h1);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("arst_bus_req",  {31'h0, bus_req},   32'h0);
    chk("arst_done",     {31'h0, done},      32'h0);
    chk("arst_stall",    {31'h0, stall},     32'h0);
    chk("arst_bus_addr", bus_addr,           32'h0);
    chk("arst_bus_be",   {28'h0, bus_be},    32'h0);
    chk("arst_rdata",    rdata,              32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h12345678, 0);
    chk("post_rdata", obs_rdata,             32'h12345678);
    chk("post_addr",  obs_addr,              32'h300);
    chk("post_done",  obs_done_cyc,          32'd3);
    chk("post_stall", obs_stall,             32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
